// File: rtl/temporal_pkg.sv
// rtl/temporal_pkg.sv - shared types for the temporal winner-take-all block
package temporal_pkg;

   typedef enum logic {
      EDGE_RISE = 1'b0,
      EDGE_FALL = 1'b1
   } edge_mode_e;

   typedef enum logic {
      TIE_ALL    = 1'b0,
      TIE_LOWEST = 1'b1
   } tie_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WON     = 2'd2,
      TIMEOUT = 2'd3
   } wta_state_e;

endpackage

// File: rtl/temporal_wta_lowest_one.sv
// rtl/temporal_wta_lowest_one.sv - lowest-set-bit finder (one-hot and index)
module lowest_one #(
   parameter int N = 8
) (
   input  logic [N-1:0]         vec,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   // two's-complement trick isolates the lowest set bit
   assign onehot = vec & (~vec + 1'b1);

   // scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/temporal_wta.sv
// rtl/temporal_wta.sv - N-channel temporal winner-take-all (earliest edge wins)
module temporal_wta
   import temporal_pkg::*;
#(
   parameter int N    = 8,
   parameter int TW   = 8,
   parameter int EDGE = 0,
   parameter int TIE  = 0
) (
   input  logic                 aclk,
   input  logic                 rst,
   input  logic                 grst,
   input  logic [N-1:0]         in_sig,
   output logic [N-1:0]         q,
   output logic [$clog2(N)-1:0] win_idx,
   output logic [TW-1:0]        win_time,
   output logic                 valid,
   output logic                 timeout
);

   localparam int IW = $clog2(N);
   localparam logic [TW-1:0] CNT_MAX = '1;

   wta_state_e      state, nxt;
   logic [TW-1:0]   cnt;
   logic [N-1:0]    prev;
   logic [N-1:0]    ev;
   logic [N-1:0]    ev_low;
   logic [IW-1:0]   ev_idx;
   logic            ev_any;

   // an event is a transition of the selected polarity since the last edge
   assign ev = (EDGE == int'(EDGE_FALL)) ? (prev & ~in_sig) : (~prev & in_sig);
   assign ev_any = |ev;

   lowest_one #(.N(N)) u_lowest (
      .vec    (ev),
      .onehot (ev_low),
      .idx    (ev_idx)
   );

   // state register
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next state: grst re-arms from anywhere, event beats a same-edge timeout
   always_comb begin
      nxt = state;
      if (grst) begin
         nxt = ARMED;
      end else if (state == ARMED) begin
         if (ev_any)              nxt = WON;
         else if (cnt == CNT_MAX) nxt = TIMEOUT;
      end
   end

   // status flags decode straight from the registered state
   always_comb begin
      valid   = (state == WON);
      timeout = (state == TIMEOUT);
   end

   // window counter, edge history and latched winner
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         prev     <= '0;
         q        <= '0;
         win_idx  <= '0;
         win_time <= '0;
      end else if (grst) begin
         // snapshot inputs so an edge coinciding with grst is not an event
         cnt      <= '0;
         prev     <= in_sig;
         q        <= '0;
         win_idx  <= '0;
         win_time <= '0;
      end else if (state == ARMED) begin
         prev <= in_sig;
         if (ev_any) begin
            q        <= (TIE == int'(TIE_LOWEST)) ? ev_low : ev;
            win_idx  <= ev_idx;
            win_time <= cnt;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_temporal_wta.sv
// tb/tb_temporal_wta.sv - directed self-checking bench for temporal_wta
module tb_temporal_wta;

   logic       aclk = 1'b0;
   logic       rst;
   logic       grst;
   logic [3:0] in_sig;
   logic [3:0] fin;

   logic [3:0] q, q_tie, q_fall;
   logic [1:0] win_idx, win_idx_tie, win_idx_fall;
   logic [3:0] win_time, win_time_tie, win_time_fall;
   logic       valid, valid_tie, valid_fall;
   logic       timeout, timeout_tie, timeout_fall;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   // rising edge, all simultaneous winners
   temporal_wta #(.N(4), .TW(4), .EDGE(0), .TIE(0)) u_dut (
      .aclk(aclk), .rst(rst), .grst(grst), .in_sig(in_sig),
      .q(q), .win_idx(win_idx), .win_time(win_time),
      .valid(valid), .timeout(timeout)
   );

   // rising edge, lowest index only
   temporal_wta #(.N(4), .TW(4), .EDGE(0), .TIE(1)) u_tie (
      .aclk(aclk), .rst(rst), .grst(grst), .in_sig(in_sig),
      .q(q_tie), .win_idx(win_idx_tie), .win_time(win_time_tie),
      .valid(valid_tie), .timeout(timeout_tie)
   );

   // falling edge
   temporal_wta #(.N(4), .TW(4), .EDGE(1), .TIE(0)) u_fall (
      .aclk(aclk), .rst(rst), .grst(grst), .in_sig(fin),
      .q(q_fall), .win_idx(win_idx_fall), .win_time(win_time_fall),
      .valid(valid_fall), .timeout(timeout_fall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, leaving time 1 unit after the last one
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // pulse grst across one edge (that edge is E0)
   task automatic arm();
      grst = 1'b1;
      tick(1);
      grst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      grst   = 1'b0;
      in_sig = 4'b0000;
      fin    = 4'b0000;
      tick(2);
      check("rst_q",        q,        0);
      check("rst_idx",      win_idx,  0);
      check("rst_time",     win_time, 0);
      check("rst_valid",    valid,    0);
      check("rst_timeout",  timeout,  0);
      rst = 1'b0;
      tick(2);
      check("idle_valid",   valid,    0);

      // single rise on [2] sampled at E3; fall instance sees only a rise
      fin = 4'b1011;
      arm();
      fin = 4'b1111;
      tick(2);
      check("t1_pre_valid", valid,      0);
      check("fall_rise_ign", valid_fall, 0);
      in_sig = 4'b0100;
      tick(1);
      check("t1_q",         q,        4'b0100);
      check("t1_idx",       win_idx,  2);
      check("t1_time",      win_time, 2);
      check("t1_valid",     valid,    1);
      check("t1_tie_q",     q_tie,    4'b0100);
      in_sig = 4'b0101;
      tick(2);
      check("t1_hold_q",    q,        4'b0100);
      check("t1_hold_time", win_time, 2);

      // tie between [1] and [3] sampled at E5
      in_sig = 4'b0000;
      arm();
      tick(4);
      in_sig = 4'b1010;
      tick(1);
      check("t2_q",         q,            4'b1010);
      check("t2_idx",       win_idx,      1);
      check("t2_time",      win_time,     4);
      check("t2_tie_q",     q_tie,        4'b0010);
      check("t2_tie_idx",   win_idx_tie,  1);
      check("t2_tie_time",  win_time_tie, 4);

      // falling edge on [0] sampled at E1
      in_sig = 4'b0000;
      fin    = 4'b1111;
      arm();
      fin = 4'b1110;
      tick(1);
      check("fall_q",       q_fall,        4'b0001);
      check("fall_time",    win_time_fall, 0);
      check("fall_valid",   valid_fall,    1);

      // no activity: timeout after E16
      arm();
      tick(15);
      check("t3_pre_to",    timeout,  0);
      tick(1);
      check("t3_timeout",   timeout,  1);
      check("t3_q",         q,        0);
      check("t3_valid",     valid,    0);
      in_sig = 4'b0001;
      tick(2);
      check("t3_ign_valid", valid,    0);
      check("t3_ign_to",    timeout,  1);

      // event on the last window edge E16 beats timeout
      in_sig = 4'b0000;
      arm();
      tick(15);
      in_sig = 4'b1000;
      tick(1);
      check("t4_valid",     valid,    1);
      check("t4_time",      win_time, 15);
      check("t4_timeout",   timeout,  0);
      check("t4_idx",       win_idx,  3);

      // rise coincident with grst is discarded; rise at E2 wins with time 1
      in_sig = 4'b0000;
      tick(1);
      in_sig = 4'b0010;
      arm();
      tick(1);
      check("t5_coinc",     valid,    0);
      in_sig = 4'b0011;
      tick(1);
      check("t5_q",         q,        4'b0001);
      check("t5_time",      win_time, 1);
      check("t5_idx",       win_idx,  0);

      // asynchronous reset clears a latched winner between edges
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_q",     q,        0);
      check("t6_async_valid", valid,    0);
      check("t6_async_time",  win_time, 0);
      tick(1);
      rst    = 1'b0;
      in_sig = 4'b0000;
      tick(1);
      in_sig = 4'b0100;
      tick(3);
      check("t6_nogrst",    valid,    0);
      in_sig = 4'b0000;
      arm();
      tick(1);
      in_sig = 4'b0100;
      tick(1);
      check("t6_resume_q",  q,        4'b0100);
      check("t6_resume_t",  win_time, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/temporal_wta.md
# temporal_wta

N-channel temporal winner-take-all: the parametrised successor to the two-input greater_than primitive. In each gamma cycle, every input line carries one temporally encoded value, represented by the arrival time of its edge. The block timestamps the first arrival against a local counter and latches the winning channel(s), so earliest arrival means smallest value. It sits between spike-encoding front ends and column/neuron logic in the race-logic datapath, and replaces chains of pairwise greater_than cells.

## Interface
- N, 8: number of input channels (≥2)
- TW, 8: timestamp/counter width; the window spans times 0..2^TW−1
- EDGE, 0: event polarity; 0 = rising (0→1), 1 = falling (1→0)
- TIE, 0: tie policy; 0 = all simultaneous earliest channels win; 1 = only the lowest index wins

- aclk  in  1  sole clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- grst  in  1  synchronous gamma-cycle restart; arms a new comparison window
- in_sig  in  N  temporally encoded inputs; must be synchronous to aclk
- q  out  N  winner vector; sticky until grst/rst
- win_idx  out  $clog2(N)  lowest index set in q
- win_time  out  TW  arrival time of the winning event
- valid  out  1  a winner is latched
- timeout  out  1  window expired with no event

## Operation
- States: IDLE, ARMED, WON, TIMEOUT.
- rst asserted: state goes to IDLE; q=0, win_idx=0, win_time=0, valid=0, timeout=0, cnt=0, prev=0.
- IDLE: ignores in_sig and waits for grst.
- grst in any state (priority over everything except rst):
  - state ← ARMED, cnt ← 0, prev ← in_sig
  - q, valid, timeout, win_idx, win_time ← 0
  - an edge coinciding with grst is discarded
- ARMED, per edge:
  - event vector ev[i] = EDGE ? (prev[i] & ~in_sig[i]) : (~prev[i] & in_sig[i])
  - prev ← in_sig
  - if ev≠0: q ← ev (TIE=0) or the lowest set bit of ev (TIE=1); win_idx ← lowest set index; win_time ← cnt; valid ← 1; state ← WON
  - else if cnt == 2^TW−1: timeout ← 1; state ← TIMEOUT
  - else cnt ← cnt+1
- An event at the last window edge wins over timeout.
- WON/TIMEOUT: outputs hold, in_sig is ignored, cnt is frozen; the only exits are grst or rst.
- Edges of opposite polarity, and a channel that bounces back after its edge, never produce events.

## Timing
- Time base: the grst edge is E0. An event sampled at edge Ek (k≥1) has win_time = k−1. An input that toggles just after E0 therefore reads as time 0.
- Outputs are registered. q/valid/win_time become visible after the edge that detects the event: 1-cycle latency from sampling.
- timeout rises after edge E(2^TW) when no event has occurred.
- rst mid-window clears outputs immediately (asynchronously). A grst is then required before the next comparison.

## Structure
- Package temporal_pkg holds:
  - edge_mode_e (EDGE_RISE, EDGE_FALL)
  - tie_mode_e (TIE_ALL, TIE_LOWEST)
  - wta_state_e (IDLE, ARMED, WON, TIMEOUT)
- Sub-module lowest_one: parametric N-bit lowest-set-bit finder. Outputs a one-hot vector and an index. Used for both TIE=1 masking and win_idx.
- Event detection, counter and FSM live in temporal_wta.

## Test plan
- N=4, TW=4, EDGE=0, TIE=0: grst, then in_sig[2] rises before E3 → at E3 q=4'b0100, win_idx=2, win_time=2, valid=1. A later rise on [0] leaves the outputs unchanged.
- Same config, [1] and [3] rise before E5 → q=4'b1010, win_idx=1, win_time=4. Rerun with TIE=1 → q=4'b0010.
- EDGE=1: all inputs high at grst, [0] falls before E1 → q=4'b0001, win_time=0. A rising edge on [2] first yields no event.
- No input activity for 16 edges after grst → timeout=1 after E16, q=0, valid=0. An event sampled at E16 instead gives valid=1, win_time=15, timeout=0.
- A rise coincides with grst → ignored, no win. Then a rise before E2 → win_time=1.
- rst asserted mid-ARMED → all outputs 0 asynchronously. Subsequent edges without grst produce no win; after grst, normal operation resumes.
